// File: rtl/circle_sweep_ctrl_if.sv
// Point/result handshake between the sweep controller and the in-circle
// comparator.
//   pt_valid, pt_x, pt_y   : point offered by the controller
//   pt_ready               : comparator accepts the offered point
//   res_valid              : comparator result strobe
//   res_in_circle          : comparator verdict, meaningful with res_valid
// master = controller side, slave = comparator side.
interface circle_sweep_ctrl_if;
    logic       pt_valid;
    logic       pt_ready;
    logic [9:0] pt_x;
    logic [9:0] pt_y;
    logic       res_valid;
    logic       res_in_circle;

    modport master (
        output pt_valid, pt_x, pt_y,
        input  pt_ready, res_valid, res_in_circle
    );

    modport slave (
        input  pt_valid, pt_x, pt_y,
        output pt_ready, res_valid, res_in_circle
    );
endinterface

// File: rtl/circle_sweep_ctrl.sv
// Sweep controller: walks every grid point (x outer, y inner) from (0,0) to
// (x_max,y_max), offers each one to an in-circle comparator, waits for its
// verdict and accumulates hit/total counts. A missing verdict for TIMEOUT
// cycles aborts the sweep into an error state.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : one-cycle sweep request (honoured in IDLE/DONE/ERROR)
//   x_max, y_max        : inclusive sweep limits, captured at start
//   cmp                 : point/result handshake (master side)
//   busy                : sweep in progress
//   done, err           : sweep completed / aborted, held until next start
//   hit_count           : results with res_in_circle=1
//   total_count         : results received
module circle_sweep_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [9:0]                 x_max,
    input  logic [9:0]                 y_max,
    circle_sweep_ctrl_if.master        cmp,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [20:0]                hit_count,
    output logic [20:0]                total_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] x_lim;
    logic [9:0] y_lim;
    logic [7:0] timer;

    logic start_acc;
    logic xfer;
    logic res_take;
    logic last_pt;

    always_comb begin
        start_acc  = 1'b0;
        xfer       = 1'b0;
        res_take   = 1'b0;
        last_pt    = (x == x_lim) && (y == y_lim);
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmp.pt_ready) begin
                    xfer       = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving in the expiry cycle takes priority.
                if (cmp.res_valid) begin
                    res_take   = 1'b1;
                    state_next = last_pt ? S_DONE : S_ISSUE;
                end else if (timer == TIMER_LAST) begin
                    state_next = S_ERROR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            timer       <= '0;
            hit_count   <= '0;
            total_count <= '0;
        end else if (start_acc) begin
            x           <= '0;
            y           <= '0;
            timer       <= '0;
            hit_count   <= '0;
            total_count <= '0;
        end else begin
            if (xfer) begin
                timer <= '0;
            end
            if (res_take) begin
                total_count <= total_count + 21'd1;
                hit_count   <= hit_count + 21'(cmp.res_in_circle);
                // The final point stays on the outputs once DONE is reached.
                if (!last_pt) begin
                    if (y == y_lim) begin
                        y <= '0;
                        x <= x + 10'd1;
                    end else begin
                        y <= y + 10'd1;
                    end
                end
            end else if (state == S_WAIT) begin
                timer <= timer + 8'd1;
            end
        end
    end

    // Limits are only meaningful inside a sweep, so they need no reset.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            x_lim <= x_max;
            y_lim <= y_max;
        end
    end

    assign cmp.pt_valid = (state == S_ISSUE);
    assign cmp.pt_x     = x;
    assign cmp.pt_y     = y;
    assign busy         = (state == S_ISSUE) || (state == S_WAIT);
    assign done         = (state == S_DONE);
    assign err          = (state == S_ERROR);

endmodule

// File: tb/tb_circle_sweep_ctrl.sv
// Self-checking bench for circle_sweep_ctrl: directed sweeps with a point
// scoreboard, stall, timeout, expiry race, start-in-WAIT and mid-sweep reset,
// and a full 100x100 sweep against an x*x+y*y<10000 model.
module tb_circle_sweep_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  x_max;
    logic [9:0]  y_max;
    logic        busy;
    logic        done;
    logic        err;
    logic [20:0] hit_count;
    logic [20:0] total_count;

    circle_sweep_ctrl_if cmp ();

    circle_sweep_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .x_max       (x_max),
        .y_max       (y_max),
        .cmp         (cmp),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .hit_count   (hit_count),
        .total_count (total_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       r;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep. Results come from the model or from pat (bit i for
    // point i mod 4). stall_idx holds pt_ready low on that point for 5 cycles
    // while pulsing res_valid, which must be ignored outside WAIT.
    task automatic run_sweep(input logic [9:0] xm, input logic [9:0] ym,
                             input bit use_model, input logic [3:0] pat,
                             input int stall_idx, input bit wiggle);
        exp_t e;
        int   hits = 0;
        int   npts = 0;
        int   idx  = 0;
        int   n;
        for (int xi = 0; xi <= int'(xm); xi++) begin
            for (int yi = 0; yi <= int'(ym); yi++) begin
                e.x = 10'(xi);
                e.y = 10'(yi);
                e.r = use_model ? ((xi * xi + yi * yi) < 10000) : pat[npts % 4];
                hits += int'(e.r);
                exp_q.push_back(e);
                npts++;
            end
        end
        x_max = xm;
        y_max = ym;
        start = 1'b1;
        tick;
        start = 1'b0;
        if (wiggle) begin
            x_max = 10'd3;
            y_max = 10'd7;
        end
        while (exp_q.size() > 0) begin
            n = 0;
            while (!cmp.pt_valid && n < 20) begin
                tick;
                n++;
            end
            if (n >= 20) begin
                check("pt_valid_timeout", 0, 1);
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            check("pt_x", cmp.pt_x, e.x);
            check("pt_y", cmp.pt_y, e.y);
            if (idx == stall_idx) begin
                cmp.pt_ready      = 1'b0;
                cmp.res_valid     = 1'b1;
                cmp.res_in_circle = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    tick;
                    check("stall_pt_valid", cmp.pt_valid, 1);
                    check("stall_pt_x", cmp.pt_x, e.x);
                    check("stall_pt_y", cmp.pt_y, e.y);
                    check("stall_err", err, 0);
                    check("stall_total", total_count, idx);
                end
                cmp.res_valid = 1'b0;
                cmp.pt_ready  = 1'b1;
            end
            tick;
            check("wait_pt_valid", cmp.pt_valid, 0);
            check("wait_busy", busy, 1);
            cmp.res_valid     = 1'b1;
            cmp.res_in_circle = e.r;
            tick;
            cmp.res_valid     = 1'b0;
            cmp.res_in_circle = 1'b0;
            idx++;
        end
        check("sweep_done", done, 1);
        check("sweep_busy", busy, 0);
        check("sweep_pt_valid", cmp.pt_valid, 0);
        check("sweep_hits", hit_count, hits);
        check("sweep_total", total_count, npts);
    endtask

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        x_max             = '0;
        y_max             = '0;
        cmp.pt_ready      = 1'b1;
        cmp.res_valid     = 1'b0;
        cmp.res_in_circle = 1'b0;
        tick;
        tick;
        check("rst_pt_valid", cmp.pt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_total", total_count, 0);
        reset = 1'b0;
        tick;

        // Single point, then 2x2 with results 1,0,1,1, then stall on (0,1).
        run_sweep(10'd0, 10'd0, 1'b0, 4'b0001, -1, 1'b0);
        run_sweep(10'd1, 10'd1, 1'b0, 4'b1101, -1, 1'b0);
        run_sweep(10'd0, 10'd1, 1'b0, 4'b0011, 1, 1'b0);

        // Timeout: no result after the first transfer.
        x_max = 10'd1;
        y_max = 10'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("to_pt_valid", cmp.pt_valid, 1);
        tick;
        repeat (TIMEOUT - 1) tick;
        check("to_err_early", err, 0);
        check("to_busy_early", busy, 1);
        tick;
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_total", total_count, 0);
        check("to_done", done, 0);
        tick;
        check("to_err_hold", err, 1);

        // Restart from ERROR clears err.
        start = 1'b1;
        tick;
        start = 1'b0;
        check("restart_err", err, 0);
        check("restart_busy", busy, 1);
        check("restart_total", total_count, 0);

        // Result in the expiry cycle wins over the timeout.
        tick;
        repeat (TIMEOUT - 1) tick;
        cmp.res_valid     = 1'b1;
        cmp.res_in_circle = 1'b1;
        tick;
        cmp.res_valid     = 1'b0;
        cmp.res_in_circle = 1'b0;
        check("race_err", err, 0);
        check("race_total", total_count, 1);
        check("race_hits", hit_count, 1);
        check("race_pt_valid", cmp.pt_valid, 1);
        check("race_pt_y", cmp.pt_y, 1);

        // Start pulsed in WAIT is ignored; reset then clears everything at once.
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("sw_pt_x", cmp.pt_x, 0);
        check("sw_pt_y", cmp.pt_y, 1);
        check("sw_total", total_count, 1);
        check("sw_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_pt_valid", cmp.pt_valid, 0);
        check("ar_pt_y", cmp.pt_y, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        check("ar_err", err, 0);
        check("ar_hits", hit_count, 0);
        check("ar_total", total_count, 0);
        check("ar_timer", dut.timer, 0);
        #1;
        reset = 1'b0;
        tick;
        tick;
        check("idle_busy", busy, 0);
        check("idle_pt_valid", cmp.pt_valid, 0);

        // Full 100x100 sweep with the limit inputs disturbed mid-sweep.
        run_sweep(10'd99, 10'd99, 1'b1, 4'b0000, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/circle_sweep_ctrl.md
CIRCLE_SWEEP_CTRL -- requirements
Module: circle_sweep_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, number of WAIT cycles without res_valid before the sweep aborts (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-004 SHALL have port: start  input  1  single-cycle request to begin a sweep.
REQ-005 SHALL have port: x_max  input  10  last x coordinate of the sweep, inclusive.
REQ-006 SHALL have port: y_max  input  10  last y coordinate of the sweep, inclusive.
REQ-007 SHALL have port: pt_valid  output  1  point offered to the in-circle comparator.
REQ-008 SHALL have port: pt_ready  input  1  comparator accepts the point.
REQ-009 SHALL have port: pt_x, pt_y  output  10 each  coordinates of the offered point.
REQ-010 SHALL have port: res_valid  input  1  comparator result strobe.
REQ-011 SHALL have port: res_in_circle  input  1  comparator result, meaningful only when res_valid=1.
REQ-012 SHALL have port: busy  output  1  sweep in progress (ISSUE or WAIT).
REQ-013 SHALL have port: done  output  1  sweep completed; level signal.
REQ-014 SHALL have port: err  output  1  sweep aborted on timeout; level signal.
REQ-015 SHALL have port: hit_count  output  21  number of results with res_in_circle=1.
REQ-016 SHALL have port: total_count  output  21  number of results received.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, DONE, ERROR.
REQ-018 SHALL accept start only in IDLE, DONE or ERROR; start in ISSUE or WAIT has no effect.
REQ-019 On an accepted start, the block SHALL latch x_max/y_max, set coordinates to (0,0), clear hit_count, total_count, done and err, and enter ISSUE, so pt_valid is 1 in the next cycle.
REQ-020 Sweep order SHALL be y inner, x outer: (0,0),(0,1)..(0,y_max),(1,0)..(x_max,y_max); total points = (x_max+1)*(y_max+1), max 2^20, no counter overflow.
REQ-021 In ISSUE, pt_valid SHALL be 1; pt_x/pt_y SHALL be stable until the transfer cycle (pt_valid=1 and pt_ready=1), after which the block enters WAIT and pt_valid drops.
REQ-022 pt_valid SHALL be 0 in every state other than ISSUE.
REQ-023 In WAIT, on res_valid=1 the block SHALL increment total_count and, if res_in_circle=1, hit_count.
REQ-024 In that same cycle, the block SHALL enter DONE if the point was (x_max,y_max); otherwise it SHALL advance the coordinates and enter ISSUE, making the next pt_valid visible one cycle after res_valid.
REQ-025 Coordinate advance SHALL work as follows: if y=y_max, then y<=0 and x<=x+1; otherwise y<=y+1.
REQ-026 res_valid outside WAIT SHALL be ignored, with no count change.
REQ-027 The WAIT timer SHALL clear on entry to WAIT and increment each WAIT cycle without res_valid; when it reaches TIMEOUT, the block SHALL enter ERROR with err=1 and hold the counts.
REQ-028 res_valid in the cycle the timer would expire SHALL win: the result is counted and there is no error.
REQ-029 The latched x_max/y_max SHALL be used throughout the sweep; input changes mid-sweep have no effect.
REQ-030 done SHALL be 1 only in DONE and err only in ERROR; both hold until the next accepted start or reset.
REQ-031 busy SHALL be 1 exactly in ISSUE and WAIT.

Reset
REQ-032 On reset, the block SHALL immediately enter IDLE, and all outputs SHALL read 0: pt_valid, pt_x, pt_y, busy, done, err, hit_count, total_count, and the internal timer.
REQ-033 Reset asserted mid-sweep (ISSUE or WAIT) SHALL abandon the sweep; after release, the block waits in IDLE for start.

Verification
REQ-034 A bench SHALL drive x_max=0, y_max=0, start, pt_ready=1, then res_valid with in_circle=1 two cycles later -> one point (0,0), then done=1, hit_count=1, total_count=1.
REQ-035 A bench SHALL drive x_max=1, y_max=1 with results 1,0,1,1 -> points (0,0),(0,1),(1,0),(1,1) in order, then hit_count=3, total_count=4, done=1.
REQ-036 A bench SHALL hold pt_ready=0 for 5 cycles with point (0,1) pending -> pt_valid=1 and pt_x=0, pt_y=1 stable all 5 cycles; no timeout, since the timer runs only in WAIT.
REQ-037 A bench SHALL withhold res_valid after the first transfer with TIMEOUT=16 -> err=1 after 16 WAIT cycles, busy=0, total_count=0; a new start clears err.
REQ-038 A bench SHALL pulse start in WAIT, then assert reset in WAIT -> start ignored (coordinates unchanged), then all outputs 0 immediately on reset.
REQ-039 A bench SHALL run x_max=y_max=99 against a model of x*x+y*y<10000 -> total_count=10000, hit_count equal to the model count.
